// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, start-edge detection, mid-bit sampling.
// Emits a one-cycle valid pulse with the received byte, or a frame_err pulse on a bad stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5301,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [12:0] HALF_LAST = 13'(HALF_BIT - 1);
  localparam logic [12:0] BIT_LAST  = 13'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic        rx_d_q, rx_d_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;

  always_comb begin
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    rx_d_d      = rx_s_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_d_q && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is high again at its centre was a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_d_q      <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_d_q      <= rx_d_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frame outcomes, a monitor pops them on pulses.
// Channel 0 uses a 16-clock bit; channels 1 and 2 use default timing with +/-2% sender bit period.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_bc;
  logic       rx_a, rx_b, rx_c;
  logic [7:0] d_a, d_b, d_c;
  logic       v_a, v_b, v_c;
  logic       fe_a, fe_b, fe_c;
  logic       b_a, b_b, b_c;

  uart_rx #(.CLKS_PER_BIT(16), .HALF_BIT(8)) dut_a (
    .clk(clk), .reset(rst_a), .rx(rx_a),
    .data(d_a), .valid(v_a), .frame_err(fe_a), .busy(b_a)
  );

  uart_rx dut_b (
    .clk(clk), .reset(rst_bc), .rx(rx_b),
    .data(d_b), .valid(v_b), .frame_err(fe_b), .busy(b_b)
  );

  uart_rx dut_c (
    .clk(clk), .reset(rst_bc), .rx(rx_c),
    .data(d_c), .valid(v_c), .frame_err(fe_c), .busy(b_c)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  held[3];
  logic        bprev[3];

  task automatic chk(input bit ok, input string name, input int ch,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s ch%0d: got %0h, expected %0h at %0t", name, ch, act, req, $time);
    end
  endtask

  task automatic push(input int ch, input bit is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    case (ch)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic mon(input int ch, input logic rst, input logic v, input logic fe,
                     input logic [7:0] d, input logic b);
    exp_t e;
    bit   got;
    if (!rst) begin
      chk({d, v, fe, b} == 11'd0, "reset_outs", ch, 32'({d, v, fe, b}), 32'd0);
      held[ch]  = 8'h00;
      bprev[ch] = 1'b0;
      return;
    end
    chk(!(v && fe), "valid_ferr_exclusive", ch, 32'({v, fe}), 32'd0);
    if (v || fe) begin
      got = 1'b0;
      case (ch)
        0:       if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
        1:       if (q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
        default: if (q_c.size() > 0) begin e = q_c.pop_front(); got = 1'b1; end
      endcase
      chk(got, "unexpected_pulse", ch, 32'({v, fe}), 32'd0);
      if (got) begin
        chk(fe == e.is_err, "pulse_kind_ferr", ch, 32'(fe), 32'(e.is_err));
        if (!e.is_err) held[ch] = e.data;
      end
      chk(d == held[ch], "pulse_data", ch, 32'(d), 32'(held[ch]));
      chk(!b && bprev[ch], "busy_drop", ch, 32'({bprev[ch], b}), 32'b10);
    end else begin
      chk(d == held[ch], "data_hold", ch, 32'(d), 32'(held[ch]));
    end
    bprev[ch] = b;
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, rst_a,  v_a, fe_a, d_a, b_a);
    mon(1, rst_bc, v_b, fe_b, d_b, b_b);
    mon(2, rst_bc, v_c, fe_c, d_c, b_c);
  end

  task automatic drive(input int ch, input logic val);
    case (ch)
      0:       rx_a = val;
      1:       rx_b = val;
      default: rx_c = val;
    endcase
  endtask

  task automatic idle(input int ch, input int n);
    drive(ch, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits of {stop, byte, start=0}, LSB first; line is left at the last bit.
  task automatic send_frame(input int ch, input logic [7:0] b, input logic stop,
                            input int nbits, input int bitlen);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      drive(ch, f[i]);
      repeat (bitlen) @(negedge clk);
    end
  endtask

  initial begin
    rst_a  = 1'b0;
    rst_bc = 1'b0;
    rx_a   = 1'b1;
    rx_b   = 1'b1;
    rx_c   = 1'b1;
    repeat (5) @(negedge clk);
    rst_a  = 1'b1;
    rst_bc = 1'b1;

    fork
      begin : chan_a
        int hi;
        idle(0, 20);
        push(0, 1'b0, 8'hA5);
        send_frame(0, 8'hA5, 1'b1, 10, 16);
        idle(0, 10);

        push(0, 1'b0, 8'h00);
        push(0, 1'b0, 8'hFF);
        push(0, 1'b0, 8'h3C);
        send_frame(0, 8'h00, 1'b1, 10, 16);
        send_frame(0, 8'hFF, 1'b1, 10, 16);
        send_frame(0, 8'h3C, 1'b1, 10, 16);
        idle(0, 20);

        hi = 0;
        for (int i = 0; i < 40; i++) begin
          drive(0, (i >= 4));
          @(negedge clk);
          if (b_a) hi++;
        end
        chk(hi == 8, "glitch_busy_len", 0, 32'(hi), 32'd8);
        idle(0, 10);

        push(0, 1'b1, 8'h00);
        send_frame(0, 8'h55, 1'b0, 10, 16);
        repeat (40) @(negedge clk);
        idle(0, 20);
        push(0, 1'b0, 8'h12);
        send_frame(0, 8'h12, 1'b1, 10, 16);
        idle(0, 20);

        send_frame(0, 8'hC3, 1'b1, 5, 16);
        drive(0, 1'b0);
        repeat (8) @(negedge clk);
        rst_a = 1'b0;
        drive(0, 1'b1);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        idle(0, 20);
        push(0, 1'b0, 8'h81);
        send_frame(0, 8'h81, 1'b1, 10, 16);
        idle(0, 30);
      end
      begin : chan_b
        idle(1, 10);
        push(1, 1'b0, 8'h96);
        send_frame(1, 8'h96, 1'b1, 10, 5407);
        idle(1, 100);
      end
      begin : chan_c
        idle(2, 10);
        push(2, 1'b0, 8'h69);
        send_frame(2, 8'h69, 1'b1, 10, 5195);
        idle(2, 100);
      end
    join

    repeat (10) @(negedge clk);
    chk(q_a.size() == 0, "pending_expect", 0, 32'(q_a.size()), 32'd0);
    chk(q_b.size() == 0, "pending_expect", 1, 32'(q_b.size()), 32'd0);
    chk(q_c.size() == 0, "pending_expect", 2, 32'(q_c.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5301, giving the clk cycles per UART bit (legal range 8..8191).
REQ-002 The block SHALL have parameter HALF_BIT, default CLKS_PER_BIT/2 (integer division), giving the clk cycles from start-edge detection to the start-bit sample.
REQ-003 Port clk, input, 1: single clock for all logic, rising edge.
REQ-004 Port reset, input, 1: reset, synchronous and active-low.
REQ-005 Port rx, input, 1: asynchronous serial line, idle high.
REQ-006 Port data, output, 8: last correctly framed received byte.
REQ-007 Port valid, output, 1: one-cycle pulse when data updates.
REQ-008 Port frame_err, output, 1: one-cycle pulse when a frame has a bad stop bit.
REQ-009 Port busy, output, 1: high while a frame is in progress (any state other than IDLE).

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before any use; rx_s is the synchronizer output, and rx_d is rx_s delayed one cycle.
REQ-011 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, with a 13-bit bit-timing counter cnt and a 3-bit bit index idx.
REQ-013 IDLE: on rx_d=1 and rx_s=0 (falling edge), go to START with cnt=0; otherwise stay in IDLE.
REQ-014 START: cnt increments each cycle; at cnt==HALF_BIT-1, sample rx_s:
- rx_s=0: go to DATA with cnt=0, idx=0.
- rx_s=1: treat as a glitch, return to IDLE with no output pulse.
REQ-015 DATA: cnt increments each cycle; at cnt==CLKS_PER_BIT-1:
- shift rx_s into bit idx of the shift register;
- set cnt=0;
- if idx==7, go to STOP; otherwise idx increments.
REQ-016 STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
- rx_s=1: data is loaded from the shift register and valid=1 for exactly that following cycle.
- rx_s=0: frame_err=1 for one cycle and data is unchanged.
- Either way, return to IDLE.
REQ-017 Overall sampling SHALL land at the bit centres: each data and stop sample occurs HALF_BIT+k*CLKS_PER_BIT cycles after edge detection, for k=1..9.
REQ-018 A new start edge SHALL only be accepted in IDLE; line activity in START, DATA or STOP other than at the sample points SHALL be ignored.
REQ-019 After a frame_err with rx held low (break), the block SHALL stay in IDLE until rx_s returns high and a fresh falling edge occurs.
REQ-020 Back-to-back frames SHALL be received when the next start bit begins immediately after the stop bit, because IDLE is re-entered about half a bit before the next edge.
REQ-021 valid and frame_err SHALL never be high in the same cycle.
REQ-022 data SHALL hold its value between valid pulses; there is no ready handshake, and the consumer must capture data on valid.

Reset
REQ-023 With reset=0 at a rising clk edge, the block SHALL go to state IDLE with cnt=0, idx=0, shift register=0, data=8'h00, valid=0, frame_err=0, busy=0, and synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; reception resumes on the first falling edge after reset is released.

Verification (CLKS_PER_BIT=16, HALF_BIT=8 unless stated)
REQ-025 Single byte 8'hA5, correct framing -> exactly one valid pulse, data=8'hA5, frame_err never high, busy drops in the same cycle as the valid pulse.
REQ-026 Bytes 8'h00, 8'hFF, 8'h3C sent back-to-back with no idle gap -> three valid pulses in order with the matching data values.
REQ-027 rx low for 4 cycles then high (glitch) -> return to IDLE, no valid or frame_err, busy high for about 8 cycles only.
REQ-028 Byte 8'h55 with stop bit=0, then rx held low for 40 cycles, then rx high followed by byte 8'h12 -> one frame_err pulse with data unchanged, no spurious frame during the break, then valid with data=8'h12.
REQ-029 reset=0 asserted during DATA bit 4 of 8'hC3, released, then 8'h81 sent -> no pulse for 8'hC3, all outputs at reset values, then valid with data=8'h81.
REQ-030 With default parameters, a frame sent with a ±2% bit-period error -> correct data is received.
